// File: rtl/hpu_pkg.sv
// Shared widths and the transmit-side state type for the HPU result stream.
package hpu_pkg;
  localparam int HPU_DW    = 32;
  localparam int HPU_DEPTH = 4;
  localparam int HPU_LEN_W = 16;

  typedef enum logic [1:0] {IDLE, SEND, DONE} put_state_t;
endpackage

// File: rtl/stream_fifo.sv
// Small circular-buffer FIFO with registered storage, no bypass, and a flush input.
module stream_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] push_data,
  output logic [DW-1:0] head_data,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  // Flush wins over any same-cycle push or pop so an abort leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/put_stream.sv
// Transmit side of the HPU result stream: buffers core results and emits a
// length-bounded valid/ready transfer with put_last on the final word.
module put_stream
  import hpu_pkg::*;
#(
  parameter int DW    = HPU_DW,
  parameter int DEPTH = HPU_DEPTH,
  parameter int LEN_W = HPU_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             start,
  input  logic [LEN_W-1:0] put_len,
  input  logic             res_v,
  input  logic [DW-1:0]    res_data,
  output logic             res_ready,
  output logic             put_valid,
  output logic [DW-1:0]    put_data,
  output logic             put_last,
  input  logic             put_ready,
  output logic             busy,
  output logic             done
);
  put_state_t       state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_m1;
  logic [LEN_W-1:0] push_cnt;
  logic [LEN_W-1:0] pop_cnt;
  logic             sending;
  logic             push;
  logic             pop;
  logic             flush;
  logic             full;
  logic             empty;
  logic [DW-1:0]    head;

  assign sending   = (state == SEND);
  assign len_m1    = len - LEN_W'(1);
  assign res_ready = sending & run & ~full & (push_cnt != len);
  assign put_valid = sending & ~empty;
  assign put_data  = put_valid ? head : '0;
  assign put_last  = put_valid & (pop_cnt == len_m1);
  assign push      = res_v & res_ready;
  assign pop       = put_valid & put_ready;
  assign flush     = sending & ~run;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  stream_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (res_data),
    .head_data (head),
    .full      (full),
    .empty     (empty)
  );

  // An abort in SEND takes priority over a final pop, so it never yields a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len      <= '0;
      push_cnt <= '0;
      pop_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && run) begin
            push_cnt <= '0;
            pop_cnt  <= '0;
            if (put_len != '0) begin
              len   <= put_len;
              state <= SEND;
            end else begin
              state <= DONE;
            end
          end
        end
        SEND: begin
          if (!run) begin
            state    <= IDLE;
            push_cnt <= '0;
            pop_cnt  <= '0;
          end else begin
            if (push) push_cnt <= push_cnt + LEN_W'(1);
            if (pop) begin
              pop_cnt <= pop_cnt + LEN_W'(1);
              if (pop_cnt == len_m1) state <= DONE;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          push_cnt <= '0;
          pop_cnt  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
